// File: rtl/dem_dwa_mchan.sv
// Multi-channel DEM encoder: maps time-multiplexed signed DSM codes onto unit-element
// selects using thermometer, DWA, bidirectional DWA or dither-randomised DWA.
module dem_dwa_mchan #(
    parameter int          NCH       = 2,
    parameter int          NELEM     = 16,
    parameter int          CODE_W    = 5,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    mclk512,
    input  logic                    reset,
    input  logic                    dem_en,
    input  logic [1:0]              dem_mode,
    input  logic                    dem_clr,
    input  logic                    dsm_valid,
    input  logic [CH_W-1:0]         dsm_ch,
    input  logic [CODE_W-1:0]       dsm_code,
    output logic [NCH*NELEM-1:0]    dem_out,
    output logic [NCH-1:0]          dem_out_valid,
    output logic                    dem_ovfl,
    output logic                    dither
);

    localparam int               PTR_W = $clog2(NELEM);
    localparam int               SUM_W = CODE_W + PTR_W + 2;
    localparam logic [CH_W:0]    NCH_L = (CH_W + 1)'(NCH);

    logic [PTR_W-1:0]        ptr [NCH];
    logic [NCH-1:0]          dir;
    logic [15:0]             lfsr;

    logic                    ch_ok;
    logic                    accept;
    logic [CH_W-1:0]         ch_idx;
    logic signed [SUM_W-1:0] sum;
    logic [PTR_W:0]          k;
    logic                    clamp;
    logic [1:0]              offset;
    logic [PTR_W-1:0]        p_cur;
    logic [PTR_W-1:0]        start;
    logic [PTR_W-1:0]        p_next;
    logic [NELEM-1:0]        mask;
    logic [NELEM-1:0]        slice;
    logic [NCH-1:0]          valid_next;
    logic                    lfsr_fb;

    // dsm_valid qualifies a sample for exactly one cycle; there is no backpressure,
    // so every accepted sample produces its slice and valid pulse on the same edge.
    always_comb begin
        ch_ok   = ({1'b0, dsm_ch} < NCH_L);
        accept  = dem_en && dsm_valid && ch_ok && !dem_clr;
        ch_idx  = ch_ok ? dsm_ch : '0;
        p_cur   = ptr[ch_idx];
        offset  = {lfsr[0], lfsr[1]};
        lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

        sum   = SUM_W'($signed(dsm_code)) + SUM_W'(NELEM / 2);
        k     = '0;
        clamp = 1'b0;
        if (sum[SUM_W-1]) begin
            clamp = 1'b1;
        end else if (sum > SUM_W'(NELEM)) begin
            k     = (PTR_W + 1)'(NELEM);
            clamp = 1'b1;
        end else begin
            k = sum[PTR_W:0];
        end

        // k == NELEM truncates to 0 here, which is exactly the mod-NELEM pointer step.
        start  = p_cur;
        p_next = p_cur;
        case (dem_mode)
            2'b00: begin
                start  = '0;
                p_next = p_cur;
            end
            2'b01: begin
                start  = p_cur;
                p_next = p_cur + k[PTR_W-1:0];
            end
            2'b10: begin
                if (!dir[ch_idx]) begin
                    start  = p_cur;
                    p_next = p_cur + k[PTR_W-1:0];
                end else begin
                    start  = p_cur - k[PTR_W-1:0];
                    p_next = p_cur - k[PTR_W-1:0];
                end
            end
            default: begin
                start  = p_cur + PTR_W'(offset);
                p_next = p_cur + PTR_W'(offset) + k[PTR_W-1:0];
            end
        endcase

        mask  = ~({NELEM{1'b1}} << k);
        slice = (mask << start) | (mask >> (NELEM - int'(start)));

        for (int c = 0; c < NCH; c++) begin
            valid_next[c] = accept && (ch_idx == CH_W'(c));
        end
    end

    always_ff @(posedge mclk512 or posedge reset) begin
        if (reset) begin
            dem_out       <= '0;
            dem_out_valid <= '0;
            dem_ovfl      <= 1'b0;
            dir           <= '0;
            lfsr          <= LFSR_SEED;
            for (int c = 0; c < NCH; c++) begin
                ptr[c] <= '0;
            end
        end else if (dem_clr) begin
            dem_out       <= '0;
            dem_out_valid <= '0;
            dem_ovfl      <= 1'b0;
            dir           <= '0;
            for (int c = 0; c < NCH; c++) begin
                ptr[c] <= '0;
            end
        end else begin
            dem_out_valid <= valid_next;
            if (accept) begin
                ptr[ch_idx]                      <= p_next;
                dem_out[ch_idx*NELEM +: NELEM]   <= slice;
                if (clamp) begin
                    dem_ovfl <= 1'b1;
                end
                if (dem_mode == 2'b10) begin
                    dir[ch_idx] <= ~dir[ch_idx];
                end
                if (dem_mode == 2'b11) begin
                    lfsr <= {lfsr_fb, lfsr[15:1]};
                end
            end
        end
    end

    assign dither = lfsr[0];

endmodule

// File: tb/tb_dem_dwa_mchan.sv
// Bench for dem_dwa_mchan: directed vector table, hand-written clear/reset sequences
// and randomized traffic checked against an element-list reference model.
module tb_dem_dwa_mchan;

    localparam int          NCH    = 2;
    localparam int          NELEM  = 16;
    localparam int          CODE_W = 5;
    localparam int          CH_W   = 1;
    localparam int          OW     = NCH * NELEM;
    localparam logic [15:0] SEED   = 16'hACE1;

    logic                 mclk512;
    logic                 reset;
    logic                 dem_en;
    logic [1:0]           dem_mode;
    logic                 dem_clr;
    logic                 dsm_valid;
    logic [CH_W-1:0]      dsm_ch;
    logic [CODE_W-1:0]    dsm_code;
    logic [OW-1:0]        dem_out;
    logic [NCH-1:0]       dem_out_valid;
    logic                 dem_ovfl;
    logic                 dither;

    dem_dwa_mchan #(
        .NCH       (NCH),
        .NELEM     (NELEM),
        .CODE_W    (CODE_W),
        .LFSR_SEED (SEED)
    ) dut (
        .mclk512       (mclk512),
        .reset         (reset),
        .dem_en        (dem_en),
        .dem_mode      (dem_mode),
        .dem_clr       (dem_clr),
        .dsm_valid     (dsm_valid),
        .dsm_ch        (dsm_ch),
        .dsm_code      (dsm_code),
        .dem_out       (dem_out),
        .dem_out_valid (dem_out_valid),
        .dem_ovfl      (dem_ovfl),
        .dither        (dither)
    );

    // clock / reset
    initial mclk512 = 1'b0;
    always #5 mclk512 = ~mclk512;

    int checks   = 0;
    int failures = 0;
    logic [OW-1:0] exp_q[$];

    // reference model state
    int             m_ptr [NCH];
    bit             m_dir [NCH];
    logic [15:0]    m_lfsr;
    logic [OW-1:0]  m_out;
    logic [NCH-1:0] m_valid;
    bit             m_ovfl;
    int             m_k;
    int             m_ch;

    int use_cnt [NCH][NELEM];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int c = 0; c < NCH; c++) begin
            m_ptr[c] = 0;
            m_dir[c] = 1'b0;
        end
        m_out   = '0;
        m_valid = '0;
        m_ovfl  = 1'b0;
    endfunction

    function automatic void model_reset();
        model_clear();
        m_lfsr = SEED;
    endfunction

    // Selects k consecutive elements, listed one by one, from the rules of each mode.
    function automatic void model_step(input bit en, input bit vld, input int ch,
                                       input logic [CODE_W-1:0] code, input logic [1:0] mode);
        int sc, k, p, s, off, idx;
        bit down;
        logic [NELEM-1:0] sl;
        m_valid = '0;
        if (!(en && vld && ch < NCH)) return;
        sc = $signed(code);
        k  = sc + NELEM / 2;
        if (k < 0) begin
            k = 0;
            m_ovfl = 1'b1;
        end else if (k > NELEM) begin
            k = NELEM;
            m_ovfl = 1'b1;
        end
        p    = m_ptr[ch];
        s    = 0;
        down = 1'b0;
        case (mode)
            2'd0: s = 0;
            2'd1: begin
                s = p;
                m_ptr[ch] = (p + k) % NELEM;
            end
            2'd2: begin
                if (!m_dir[ch]) begin
                    s = p;
                    m_ptr[ch] = (p + k) % NELEM;
                end else begin
                    down = 1'b1;
                    m_ptr[ch] = (p - k + NELEM) % NELEM;
                end
                m_dir[ch] = !m_dir[ch];
            end
            default: begin
                off = 2 * int'(m_lfsr[0]) + int'(m_lfsr[1]);
                s = (p + off) % NELEM;
                m_ptr[ch] = (s + k) % NELEM;
                m_lfsr = {^(m_lfsr & 16'h002D), m_lfsr[15:1]};
            end
        endcase
        sl = '0;
        for (int j = 0; j < k; j++) begin
            if (down) idx = (p - 1 - j + 2 * NELEM) % NELEM;
            else      idx = (s + j) % NELEM;
            sl[idx] = 1'b1;
        end
        m_out[ch*NELEM +: NELEM] = sl;
        m_valid[ch] = 1'b1;
        m_k  = k;
        m_ch = ch;
    endfunction

    // driver: one cycle of stimulus, then scoreboard compare after the edge
    task automatic step(input bit en, input bit vld, input int ch, input int code,
                        input logic [1:0] mode, input bit clr);
        logic [CODE_W-1:0] cb;
        logic [OW-1:0] e;
        cb = code[CODE_W-1:0];
        @(negedge mclk512);
        dem_en    = en;
        dsm_valid = vld;
        dsm_ch    = ch[CH_W-1:0];
        dsm_code  = cb;
        dem_mode  = mode;
        dem_clr   = clr;
        if (clr) model_clear();
        else     model_step(en, vld, ch, cb, mode);
        exp_q.push_back(m_out);
        @(posedge mclk512);
        #1;
        e = exp_q.pop_front();
        chk("dem_out", dem_out, e);
        chk("dem_out_valid", dem_out_valid, m_valid);
        chk("dem_ovfl", dem_ovfl, m_ovfl);
        chk("dither", dither, m_lfsr[0]);
        if (m_valid != '0) begin
            chk("popcount", $countones(dem_out[m_ch*NELEM +: NELEM]), m_k);
        end
    endtask

    task automatic idle();
        @(negedge mclk512);
        dsm_valid = 1'b0;
        dem_clr   = 1'b0;
    endtask

    typedef struct {
        bit             clr_first;
        logic [1:0]     mode;
        int             ch;
        int             code;
        logic [OW-1:0]  exp_out;
        logic [NCH-1:0] exp_valid;
        bit             exp_ovfl;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [15:0] seed_v;
        int mx, mn;
        seed_v = SEED;

        vecs[0]  = '{1'b1, 2'd1, 0,  0, 32'h0000_00FF, 2'b01, 1'b0};
        vecs[1]  = '{1'b0, 2'd1, 0,  3, 32'h0000_FF07, 2'b01, 1'b0};
        vecs[2]  = '{1'b1, 2'd0, 1, -8, 32'h0000_0000, 2'b10, 1'b0};
        vecs[3]  = '{1'b0, 2'd0, 1,  8, 32'hFFFF_0000, 2'b10, 1'b0};
        vecs[4]  = '{1'b0, 2'd0, 1,  9, 32'hFFFF_0000, 2'b10, 1'b1};
        vecs[5]  = '{1'b0, 2'd0, 1,  0, 32'h00FF_0000, 2'b10, 1'b1};
        vecs[6]  = '{1'b1, 2'd1, 0, -3, 32'h0000_001F, 2'b01, 1'b0};
        vecs[7]  = '{1'b0, 2'd1, 1, -3, 32'h001F_001F, 2'b10, 1'b0};
        vecs[8]  = '{1'b0, 2'd1, 0, -3, 32'h001F_03E0, 2'b01, 1'b0};
        vecs[9]  = '{1'b1, 2'd2, 0, -4, 32'h0000_000F, 2'b01, 1'b0};
        vecs[10] = '{1'b0, 2'd2, 0, -6, 32'h0000_000C, 2'b01, 1'b0};
        vecs[11] = '{1'b0, 2'd2, 0,  0, 32'h0000_03FC, 2'b01, 1'b0};
        vecs[12] = '{1'b0, 2'd2, 1,  8, 32'hFFFF_03FC, 2'b10, 1'b0};

        reset = 1'b1; dem_en = 1'b0; dem_mode = 2'd0; dem_clr = 1'b0;
        dsm_valid = 1'b0; dsm_ch = '0; dsm_code = '0;
        model_reset();
        repeat (2) @(posedge mclk512);
        #1;
        chk("reset_out", dem_out, '0);
        chk("reset_valid", dem_out_valid, '0);
        chk("reset_ovfl", dem_ovfl, 1'b0);
        chk("reset_dither", dither, seed_v[0]);
        @(negedge mclk512);
        reset = 1'b0;

        // directed vector table
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].clr_first) step(1'b1, 1'b1, 0, 5, vecs[i].mode, 1'b1);
            step(1'b1, 1'b1, vecs[i].ch, vecs[i].code, vecs[i].mode, 1'b0);
            chk("tbl_out", dem_out, vecs[i].exp_out);
            chk("tbl_valid", dem_out_valid, vecs[i].exp_valid);
            chk("tbl_ovfl", dem_ovfl, vecs[i].exp_ovfl);
        end

        // dem_en low: sample ignored, outputs hold
        step(1'b0, 1'b1, 0, 5, 2'd1, 1'b0);
        chk("en_hold_out", dem_out, 32'hFFFF_03FC);
        chk("en_hold_valid", dem_out_valid, 2'b00);

        // negative saturation then clear with a coincident sample
        step(1'b1, 1'b1, 1, -9, 2'd0, 1'b0);
        chk("neg_sat_ovfl", dem_ovfl, 1'b1);
        chk("neg_sat_out", dem_out, 32'h0000_03FC);
        step(1'b1, 1'b1, 0, 4, 2'd1, 1'b1);
        chk("clr_out", dem_out, '0);
        chk("clr_valid", dem_out_valid, '0);
        chk("clr_ovfl", dem_ovfl, 1'b0);
        step(1'b1, 1'b1, 0, 0, 2'd1, 1'b0);
        chk("after_clr_out", dem_out, 32'h0000_00FF);

        // asynchronous reset mid-stream
        step(1'b1, 1'b1, 0, 3, 2'd3, 1'b0);
        step(1'b1, 1'b1, 1, -2, 2'd3, 1'b0);
        step(1'b1, 1'b1, 0, 9, 2'd3, 1'b0);
        idle();
        @(posedge mclk512);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_out", dem_out, '0);
        chk("midrst_valid", dem_out_valid, '0);
        chk("midrst_ovfl", dem_ovfl, 1'b0);
        chk("midrst_dither", dither, seed_v[0]);
        model_reset();
        @(negedge mclk512);
        reset = 1'b0;
        step(1'b1, 1'b1, 0, 0, 2'd1, 1'b0);
        chk("after_rst_out", dem_out, 32'h0000_00FF);

        // random DWA traffic with element usage balance
        step(1'b1, 1'b1, 0, 0, 2'd1, 1'b1);
        for (int c = 0; c < NCH; c++)
            for (int e = 0; e < NELEM; e++) use_cnt[c][e] = 0;
        for (int i = 0; i < 300; i++) begin
            int ch, code;
            ch   = int'($urandom_range(0, NCH - 1));
            code = int'($urandom_range(0, 16)) - 8;
            step($urandom_range(0, 19) != 0, $urandom_range(0, 9) != 0, ch, code, 2'd1, 1'b0);
            for (int c = 0; c < NCH; c++)
                if (dem_out_valid[c])
                    for (int e = 0; e < NELEM; e++) use_cnt[c][e] += int'(dem_out[c*NELEM + e]);
        end
        for (int c = 0; c < NCH; c++) begin
            mx = use_cnt[c][0];
            mn = use_cnt[c][0];
            for (int e = 1; e < NELEM; e++) begin
                if (use_cnt[c][e] > mx) mx = use_cnt[c][e];
                if (use_cnt[c][e] < mn) mn = use_cnt[c][e];
            end
            chk("dwa_usage_spread_ok", (mx - mn) <= 2, 1'b1);
        end

        // random randomised-DWA traffic, including out-of-range codes
        for (int i = 0; i < 1000; i++) begin
            int ch, code;
            ch   = int'($urandom_range(0, NCH - 1));
            code = int'($urandom_range(0, 18)) - 9;
            step($urandom_range(0, 19) != 0, $urandom_range(0, 9) != 0, ch, code, 2'd3, 1'b0);
        end

        // random mode changes with retained pointer/direction/LFSR state
        for (int i = 0; i < 300; i++) begin
            int ch, code;
            logic [1:0] md;
            ch   = int'($urandom_range(0, NCH - 1));
            code = int'($urandom_range(0, 16)) - 8;
            md   = 2'($urandom_range(0, 3));
            step(1'b1, $urandom_range(0, 7) != 0, ch, code, md, $urandom_range(0, 49) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL timeout: simulation did not complete within 500000 time units");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
